// File: rtl/gaus_pkg.sv
// Shared constants and types for the Gaussian pipeline blocks
// (read scheduler, buffer, shifter, hold).
package gaus_pkg;

   localparam int ADDR_W    = 20;
   localparam int ROW_WORDS = 256;
   localparam int NUM_ROWS  = 5;

   typedef enum logic [2:0] {
      P0 = 3'd0,
      P1 = 3'd1,
      P2 = 3'd2,
      P3 = 3'd3,
      P4 = 3'd4
   } phase_e;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } sched_state_e;

endpackage

// File: rtl/gaus_read_scheduler.sv
// Issues the 5-row interleaved SRAM read stream (newest row first per column)
// and the matching buffer-pop / shift enables one cycle behind each issue.
module gaus_read_scheduler #(
   parameter int ADDR_W     = gaus_pkg::ADDR_W,
   parameter int ROW_WORDS  = gaus_pkg::ROW_WORDS,
   parameter int START_ADDR = 1024,
   parameter int END_ADDR   = 524287
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              stall,
   output logic [ADDR_W-1:0] read_addr,
   output logic              rd_issue,
   output logic [2:0]        rd_phase,
   output logic              pop_buffer_en,
   output logic              shift_en,
   output logic              busy,
   output logic              done
);
   import gaus_pkg::*;

   if (START_ADDR < 4 * ROW_WORDS) begin : g_chk_start
      $fatal(1, "START_ADDR must be at least 4*ROW_WORDS");
   end
   if (END_ADDR < START_ADDR) begin : g_chk_end
      $fatal(1, "END_ADDR must not be below START_ADDR");
   end

   localparam logic [ADDR_W-1:0] START_A = ADDR_W'(START_ADDR);
   localparam logic [ADDR_W-1:0] END_A   = ADDR_W'(END_ADDR);
   localparam logic [ADDR_W-1:0] STRIDE  = ADDR_W'(ROW_WORDS);

   sched_state_e      state_q, state_d;
   logic [ADDR_W-1:0] sched_q, sched_d;
   logic [ADDR_W-1:0] read_addr_q, read_addr_d;
   phase_e            phase_q, phase_d;
   phase_e            rd_phase_q, rd_phase_d;
   logic              rd_issue_q, rd_issue_d;
   logic              pop_q, pop_d;
   logic              shift_q, shift_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;

   always_comb begin
      state_d     = state_q;
      sched_d     = sched_q;
      phase_d     = phase_q;
      read_addr_d = read_addr_q;
      rd_phase_d  = rd_phase_q;
      rd_issue_d  = 1'b0;
      // SRAM returns one cycle after issue, so the enables trail rd_issue by one.
      pop_d       = rd_issue_q && (rd_phase_q < P4);
      shift_d     = rd_issue_q && (rd_phase_q == P4);
      busy_d      = (state_q == RUN) || (state_q == DRAIN);
      done_d      = (state_q == DONE);

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = RUN;
               sched_d = START_A;
               phase_d = P0;
            end
         end
         RUN: begin
            if (phase_q > P4) begin
               phase_d = P0;
            end else if (!stall) begin
               read_addr_d = sched_q - ADDR_W'(phase_q) * STRIDE;
               rd_issue_d  = 1'b1;
               rd_phase_d  = phase_q;
               if (phase_q == P4) begin
                  phase_d = P0;
                  if (sched_q == END_A) begin
                     state_d = DRAIN;
                  end else begin
                     sched_d = sched_q + ADDR_W'(1);
                  end
               end else begin
                  phase_d = phase_e'(phase_q + 3'd1);
               end
            end
         end
         DRAIN:   state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         sched_q     <= START_A;
         phase_q     <= P0;
         read_addr_q <= START_A;
         rd_phase_q  <= P0;
         rd_issue_q  <= 1'b0;
         pop_q       <= 1'b0;
         shift_q     <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         sched_q     <= sched_d;
         phase_q     <= phase_d;
         read_addr_q <= read_addr_d;
         rd_phase_q  <= rd_phase_d;
         rd_issue_q  <= rd_issue_d;
         pop_q       <= pop_d;
         shift_q     <= shift_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign read_addr     = read_addr_q;
   assign rd_issue      = rd_issue_q;
   assign rd_phase      = rd_phase_q;
   assign pop_buffer_en = pop_q;
   assign shift_en      = shift_q;
   assign busy          = busy_q;
   assign done          = done_q;

endmodule

// File: tb/tb_gaus_read_scheduler.sv
// Bench for gaus_read_scheduler: directed scenarios plus random start/stall/reset,
// checked every cycle against a queue-based model of the issue stream.
module tb_gaus_read_scheduler;

   localparam int ADDR_W = 20;
   localparam int START  = 1024;
   localparam int END_A  = 1025;
   localparam int MASK   = (1 << ADDR_W) - 1;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              start = 1'b0;
   logic              stall = 1'b0;
   logic [ADDR_W-1:0] read_addr;
   logic              rd_issue;
   logic [2:0]        rd_phase;
   logic              pop_buffer_en;
   logic              shift_en;
   logic              busy;
   logic              done;

   always #5 clk = ~clk;

   gaus_read_scheduler #(
      .ADDR_W    (ADDR_W),
      .ROW_WORDS (256),
      .START_ADDR(START),
      .END_ADDR  (END_A)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .stall        (stall),
      .read_addr    (read_addr),
      .rd_issue     (rd_issue),
      .rd_phase     (rd_phase),
      .pop_buffer_en(pop_buffer_en),
      .shift_en     (shift_en),
      .busy         (busy),
      .done         (done)
   );

   int n_cmp = 0;
   int n_err = 0;

   // Model: pending issues of the current frame plus a post-issue tail counter.
   int q_addr[$];
   int q_ph[$];
   int m_mode = 0;        // 0 idle, 1 issuing, 2 first tail cycle, 3 second tail cycle
   int e_addr = START;
   int e_phase = 0;
   bit e_issue = 0, e_pop = 0, e_shift = 0, e_busy = 0, e_done = 0;

   int seen[$];
   int done_cnt = 0;
   int exp_list[10] = '{1024, 768, 512, 256, 0, 1025, 769, 513, 257, 1};

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_edge(input bit st, input bit sl, input bit rs);
      if (rs) begin
         q_addr.delete();
         q_ph.delete();
         m_mode = 0; e_addr = START; e_phase = 0;
         e_issue = 0; e_pop = 0; e_shift = 0; e_busy = 0; e_done = 0;
         return;
      end
      e_pop   = e_issue && (e_phase < 4);
      e_shift = e_issue && (e_phase == 4);
      e_busy  = (m_mode == 1) || (m_mode == 2);
      e_done  = (m_mode == 3);
      e_issue = 0;
      case (m_mode)
         0: if (st) begin
               for (int c = START; c <= END_A; c++)
                  for (int r = 0; r < 5; r++) begin
                     q_addr.push_back((c - r * 256) & MASK);
                     q_ph.push_back(r);
                  end
               m_mode = 1;
            end
         1: if (!sl) begin
               e_addr  = q_addr.pop_front();
               e_phase = q_ph.pop_front();
               e_issue = 1;
               if (q_addr.size() == 0) m_mode = 2;
            end
         2: m_mode = 3;
         default: m_mode = 0;
      endcase
   endtask

   task automatic step(input bit st, input bit sl, input bit rs);
      @(negedge clk);
      start = st;
      stall = sl;
      reset = rs;
      @(posedge clk);
      model_edge(st, sl, rs);
      #1;
      chk("read_addr", 32'(read_addr), 32'(e_addr));
      chk("rd_phase", 32'(rd_phase), 32'(e_phase));
      chk("rd_issue", 32'(rd_issue), 32'(e_issue));
      chk("pop_buffer_en", 32'(pop_buffer_en), 32'(e_pop));
      chk("shift_en", 32'(shift_en), 32'(e_shift));
      chk("busy", 32'(busy), 32'(e_busy));
      chk("done", 32'(done), 32'(e_done));
      chk("pop_and_shift", 32'(pop_buffer_en & shift_en), 32'd0);
      if (rd_issue === 1'b1) seen.push_back(int'(read_addr));
      if (done === 1'b1) done_cnt++;
   endtask

   task automatic clear_log();
      seen.delete();
      done_cnt = 0;
   endtask

   task automatic check_frame(input string tag);
      chk({tag, "_issues"}, 32'(seen.size()), 32'd10);
      for (int i = 0; i < 10 && i < seen.size(); i++)
         chk({tag, "_addr"}, 32'(seen[i]), 32'(exp_list[i]));
      chk({tag, "_done_pulses"}, 32'(done_cnt), 32'd1);
   endtask

   initial begin
      // Reset state
      step(0, 0, 1);
      step(0, 0, 1);
      step(0, 1, 0);

      // Plain frame, no stalls
      clear_log();
      step(1, 0, 0);
      for (int i = 1; i <= 16; i++) step(0, 0, 0);
      check_frame("plain");

      // Three stall cycles right after address 512 is issued
      clear_log();
      step(1, 0, 0);
      for (int i = 1; i <= 18; i++) step(0, (i >= 4 && i <= 6), 0);
      check_frame("stall");

      // start pulsed again at the 7th issue
      clear_log();
      step(1, 0, 0);
      for (int i = 1; i <= 16; i++) step(0, 0, (i == 7) ? 1'b0 : 1'b0) ;
      clear_log();
      step(1, 0, 0);
      for (int i = 1; i <= 16; i++) step((i == 7), 0, 0);
      check_frame("restart_busy");

      // start held while frame is finishing (DONE) must not launch a new frame
      clear_log();
      step(1, 0, 0);
      for (int i = 1; i <= 16; i++) step((i >= 11 && i <= 12), 0, 0);
      check_frame("start_in_tail");

      // reset while phase 2 is on read_addr, then a fresh start
      step(1, 0, 0);
      for (int i = 1; i <= 3; i++) step(0, 0, 0);
      chk("pre_reset_phase", 32'(rd_phase), 32'd2);
      step(1, 0, 1);
      clear_log();
      step(1, 0, 0);
      for (int i = 1; i <= 16; i++) step(0, 0, 0);
      check_frame("after_reset");

      // Random start/stall/reset traffic
      for (int i = 0; i < 1500; i++)
         step(($urandom_range(0, 9) < 2), ($urandom_range(0, 9) < 3),
              ($urandom_range(0, 199) < 3));
      for (int i = 0; i < 40; i++) step(0, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/gaus_read_scheduler.md
Name: gaus_read_scheduler

Overview:
- Upstream controller for the Gaussian pipeline. Generates the 5-row interleaved read-address stream into the input image SRAM (64-bit words, 8 pixels each, 256 words per image row).
- Drives the buffer-pop and shift enables so that the buffer block and shifter block see each returned word in the correct slot.
- Replaces free-running testbench address sequencing with a start/stall/done controlled block.

Parameters:
- ADDR_W, 20, SRAM word-address width.
- ROW_WORDS, 256, words per image row; the row stride subtracted per phase.
- START_ADDR, 1024, first "newest row" column address; must be >= 4*ROW_WORDS (elaboration-time check, fatal if violated).
- END_ADDR, 524287, last newest-row address issued; must be >= START_ADDR.

Ports:
- clk, input, 1, clock.
- reset, input, 1, synchronous, active-high reset.
- start, input, 1, single-cycle request to begin a frame; honoured only in IDLE.
- stall, input, 1, when high, no new address is issued this cycle.
- read_addr, output, ADDR_W, SRAM read address (registered).
- rd_issue, output, 1, high in cycles where read_addr carries a newly issued request.
- rd_phase, output, 3, phase 0..4 of the request currently on read_addr.
- pop_buffer_en, output, 1, high when SRAM q holds phase 0..3 data; buffer block captures it.
- shift_en, output, 1, high when SRAM q holds phase 4 data; shifter consumes q plus buffers A–D.
- busy, output, 1, high in RUN and DRAIN.
- done, output, 1, one-cycle pulse at frame end.

Behaviour:
- Reset values: read_addr = START_ADDR; rd_phase = 0; all other outputs 0; state = IDLE; internal sched = START_ADDR.
- States:
  - IDLE: start=1 → RUN, with sched = START_ADDR and phase = 0.
  - RUN: issues addresses.
  - DRAIN: one cycle for the final SRAM return → DONE.
  - DONE: done = 1 for one cycle → IDLE.
- RUN, stall=0:
  - read_addr <= sched − phase*ROW_WORDS (mod 2^ADDR_W); rd_issue <= 1; rd_phase <= phase.
  - If phase = 4: phase <= 0. Then, if sched = END_ADDR → DRAIN; else sched <= sched + 1.
  - Otherwise phase <= phase + 1.
- RUN, stall=1: read_addr, sched and phase hold; rd_issue <= 0.
- Stall never cancels an in-flight read.
- Issue order per column is newest row first: sched, sched−256, sched−512, sched−768, sched−1024.
- SRAM read latency is 1 cycle. Data for a request issued at cycle n is present on q at cycle n+1. The enables are computed accordingly:
  - pop_buffer_en(n+1) = rd_issue(n) & (rd_phase(n) < 4)
  - shift_en(n+1) = rd_issue(n) & (rd_phase(n) == 4)
  - Both are registered; they are never high together.
- Latency: start at cycle 0 → first read_addr at cycle 1 → first pop_buffer_en at cycle 2 → first shift_en at cycle 6 (no stalls).
- Frame length: 5*(END_ADDR−START_ADDR+1) issues. The done pulse comes 2 cycles after the last issue (DRAIN, then DONE).
- start while busy or in DONE: ignored, with no effect on sched.
- reset mid-frame: next cycle all outputs return to reset values, state = IDLE, and any in-flight enable is dropped.
- start and reset high together: reset wins.
- stall in IDLE, DRAIN or DONE: no effect.
- rd_phase is a 3-bit counter; values 5–7 are unreachable. If one is detected, phase is forced to 0 (defensive).

Decomposition:
- Shared package gaus_pkg holds:
  - ADDR_W and ROW_WORDS constants.
  - NUM_ROWS = 5.
  - Phase type: 3-bit, values P0..P4.
  - Scheduler state enum: IDLE, RUN, DRAIN, DONE.
- The same package is reused by the buffer, shifter and hold blocks for row-count and stride constants.
- No sub-module is natural. The 1-cycle issue→enable delay is a small register stage kept inline.

Test Plan:
- Reset, then start at cycle 0 with no stall → read_addr 1024, 768, 512, 256, 0, 1025, 769, 513, 257, 1 on cycles 1–10; rd_phase 0,1,2,3,4 repeating.
- Same run → pop_buffer_en high on cycles 2–5 and 7–10; shift_en high on cycles 6 and 11 only; never both high.
- stall held high for 3 cycles just after address 512 is issued → read_addr holds at 512 and rd_issue is 0 for those 3 cycles; after release the next addresses are 256, then 0; no address is skipped or repeated.
- START_ADDR=1024, END_ADDR=1025 → exactly 10 issues; busy falls and done pulses for exactly 1 cycle, 2 cycles after the last issue (address 1); state returns to IDLE.
- start pulsed again while busy, at the 7th issue → sequence unchanged, with exactly one frame completed.
- reset asserted during phase 2 → next cycle read_addr = 1024, all enables 0, busy 0; a new start restarts from 1024, phase 0.
